uart_mem_arbiter: RTL and testbench

Shares one uart_mem register port (enable/wr_en/addr/i_data -> ready/o_data) between NUM_REQ independent requester FSMs, e.g. a hex logger and an echo/command engine.
- Each requester uses the same hold-enable-until-ready handshake it would use on uart_mem directly.
- The arbiter grants round-robin, holds the grant for exactly one register transaction, and guarantees the downstream enable drops for at least one cycle between transactions.

---
 rtl/uart_mem_arbiter_if.sv | 34 +++
 rtl/uart_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_uart_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_arbiter_if.sv
// Bundle for uart_mem_arbiter: per-requester handshake fields plus the shared downstream uart_mem port.
// The arbiter uses the slave view; the requesters and the uart_mem model together use the master view.
interface uart_mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_enable;
    logic [NUM_REQ-1:0]        req_wr_en;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_i_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         req_o_data;
    logic [NUM_REQ-1:0]        grant;

    logic                      m_enable;
    logic                      m_wr_en;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_i_data;
    logic                      m_ready;
    logic [DATA_W-1:0]         m_o_data;

    logic                      timeout_err;

    modport slave (
        input  req_enable, req_wr_en, req_addr, req_i_data, m_ready, m_o_data,
        output req_ready, req_o_data, grant, m_enable, m_wr_en, m_addr, m_i_data, timeout_err
    );

    modport master (
        output req_enable, req_wr_en, req_addr, req_i_data, m_ready, m_o_data,
        input  req_ready, req_o_data, grant, m_enable, m_wr_en, m_addr, m_i_data, timeout_err
    );
endinterface

// File: rtl/uart_mem_arbiter.sv
// Round-robin share of one uart_mem register port: m_enable 1 cycle after request, one transaction per grant,
// grant held until the owner drops enable. UART_ARB_TIMEOUT_EN adds a ready timeout with sticky timeout_err.
module uart_mem_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic               clk,
    input logic               rst,
    uart_mem_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SCN_W = IDX_W + 1;

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_cfg
        $error("uart_mem_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [DATA_W-1:0]   req_o_data_q, req_o_data_d;
    logic                m_enable_q, m_enable_d;
    logic                m_wr_en_q, m_wr_en_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_i_data_q, m_i_data_d;

    logic                win;
    logic [IDX_W-1:0]    win_idx;
    logic [SCN_W-1:0]    scan_idx;
    logic                done;
    logic [DATA_W-1:0]   rdat;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        terr_q, terr_d;
`endif

    // First asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win      = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + SCN_W'(k);
            if (scan_idx >= SCN_W'(NUM_REQ)) begin
                scan_idx = scan_idx - SCN_W'(NUM_REQ);
            end
            if (!win && bus.req_enable[scan_idx[IDX_W-1:0]]) begin
                win     = 1'b1;
                win_idx = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gidx_d       = gidx_q;
        grant_d      = grant_q;
        req_ready_d  = '0;
        req_o_data_d = req_o_data_q;
        m_enable_d   = m_enable_q;
        m_wr_en_d    = m_wr_en_q;
        m_addr_d     = m_addr_q;
        m_i_data_d   = m_i_data_q;
        done         = 1'b0;
        rdat         = bus.m_o_data;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        terr_d       = terr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win) begin
                    gidx_d           = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    m_enable_d       = 1'b1;
                    m_wr_en_d        = bus.req_wr_en[win_idx];
                    m_addr_d         = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
                    m_i_data_d       = bus.req_i_data[win_idx*DATA_W +: DATA_W];
                    rr_ptr_d         = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d          = ACCESS;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d            = '0;
`endif
                end
            end
            ACCESS: begin
                if (bus.m_ready) done = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    done   = 1'b1;
                    rdat   = '1;
                    terr_d = 1'b1;
                end
                else cnt_d = cnt_q + 16'd1;
`endif
                // The downstream access always completes; an abandoned request only loses its ready pulse.
                if (done) begin
                    m_enable_d   = 1'b0;
                    m_wr_en_d    = 1'b0;
                    req_o_data_d = rdat;
                    if (bus.req_enable[gidx_q]) begin
                        req_ready_d[gidx_q] = 1'b1;
                        state_d             = RELEASE;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            RELEASE: begin
                if (!bus.req_enable[gidx_q]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gidx_q       <= '0;
            grant_q      <= '0;
            req_ready_q  <= '0;
            req_o_data_q <= '0;
            m_enable_q   <= 1'b0;
            m_wr_en_q    <= 1'b0;
            m_addr_q     <= '0;
            m_i_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gidx_q       <= gidx_d;
            grant_q      <= grant_d;
            req_ready_q  <= req_ready_d;
            req_o_data_q <= req_o_data_d;
            m_enable_q   <= m_enable_d;
            m_wr_en_q    <= m_wr_en_d;
            m_addr_q     <= m_addr_d;
            m_i_data_q   <= m_i_data_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant      = grant_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.req_o_data = req_o_data_q;
    assign bus.m_enable   = m_enable_q;
    assign bus.m_wr_en    = m_wr_en_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_i_data   = m_i_data_q;
endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed bench for uart_mem_arbiter with a uart_mem model and a scoreboard of expected downstream transactions.
module tb_uart_mem_arbiter;
    localparam int NR = 2;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [1:0]  idx;
        logic        wr;
        logic [2:0]  addr;
        logic [7:0]  data;
    } exp_t;

    logic clk;
    logic rst;
    logic       tb_en   [NR];
    logic       tb_wr   [NR];
    logic [2:0] tb_addr [NR];
    logic [7:0] tb_dat  [NR];
    logic [7:0] rd_table [8];
    bit         mem_on;
    int         ack_delay;
    exp_t       exp_q [$];
    int         n_checks;
    int         n_pass;
    int         n_fail;

    uart_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    uart_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.req_enable = {tb_en[1], tb_en[0]};
    assign bus.req_wr_en  = {tb_wr[1], tb_wr[0]};
    assign bus.req_addr   = {tb_addr[1], tb_addr[0]};
    assign bus.req_i_data = {tb_dat[1], tb_dat[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic wr, input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        e.idx  = 2'(idx);
        e.wr   = wr;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One full requester transaction: assert, wait for ready, check pulse, optionally keep enable high.
    task automatic req_txn(input int idx, input logic wr, input logic [2:0] a, input logic [7:0] d,
                           input int hold, input bit chk_lat);
        int cyc;
        logic [1:0] own;
        own = 2'b01 << idx;
        @(negedge clk);
        tb_wr[idx]   = wr;
        tb_addr[idx] = a;
        tb_dat[idx]  = d;
        tb_en[idx]   = 1'b1;
        if (chk_lat) begin
            @(negedge clk);
            chk("enable_latency", bus.m_enable, 1);
        end
        cyc = 0;
        while (bus.req_ready[idx] !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_seen", bus.req_ready[idx], 1);
        chk("ready_rdata", bus.req_o_data, rd_table[a]);
        chk("ready_grant", bus.grant, own);
        @(negedge clk);
        chk("ready_pulse_1cyc", bus.req_ready[idx], 0);
        for (int k = 0; k < hold; k++) begin
            chk("held_no_new_txn", {bus.m_enable, bus.grant}, {1'b0, own});
            @(negedge clk);
        end
        tb_en[idx] = 1'b0;
    endtask

    // uart_mem model: ready pulse after ack_delay cycles of enable, read data from rd_table.
    initial begin
        int en_cnt;
        en_cnt       = 0;
        bus.m_ready  = 1'b0;
        bus.m_o_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst || !mem_on) begin
                bus.m_ready = 1'b0;
                en_cnt      = 0;
            end else if (bus.m_ready) begin
                bus.m_ready = 1'b0;
                en_cnt      = 0;
            end else if (bus.m_enable) begin
                en_cnt++;
                if (en_cnt >= ack_delay) begin
                    bus.m_ready  = 1'b1;
                    bus.m_o_data = rd_table[bus.m_addr];
                end
            end else begin
                en_cnt = 0;
            end
        end
    end

    // Scoreboard: every downstream transaction start is matched against the next expected one.
    initial begin
        int   low_cnt;
        logic prev_en;
        exp_t e;
        logic [1:0] g;
        low_cnt = 100;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                low_cnt = 100;
                prev_en = 1'b0;
            end else begin
                if (bus.m_enable && !prev_en) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_txn", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        g = 2'b01 << e.idx;
                        chk("sb_grant", bus.grant, g);
                        chk("sb_wr_en", bus.m_wr_en, e.wr);
                        chk("sb_addr", bus.m_addr, e.addr);
                        chk("sb_data", bus.m_i_data, e.data);
                        chk("sb_enable_gap", low_cnt >= 2, 1);
                    end
                    low_cnt = 0;
                end else if (!bus.m_enable) begin
                    low_cnt++;
                end
                prev_en = bus.m_enable;
            end
        end
    end

    initial begin
        int cyc;
        bit saw;
        n_checks  = 0;
        n_pass    = 0;
        n_fail    = 0;
        mem_on    = 1'b1;
        ack_delay = 3;
        rd_table[0] = 8'h5A; rd_table[1] = 8'h11; rd_table[2] = 8'h22; rd_table[3] = 8'h41;
        rd_table[4] = 8'h93; rd_table[5] = 8'hA4; rd_table[6] = 8'hB5; rd_table[7] = 8'hC6;
        for (int i = 0; i < NR; i++) begin
            tb_en[i] = 1'b0; tb_wr[i] = 1'b0; tb_addr[i] = 3'd0; tb_dat[i] = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_m_enable", bus.m_enable, 0);
        chk("rst_outputs", {bus.req_ready, bus.req_o_data, bus.m_wr_en, bus.m_addr, bus.m_i_data}, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        rst = 1'b0;

        // Single write from requester 0.
        push(0, 1'b1, 3'd0, 8'hD5);
        req_txn(0, 1'b1, 3'd0, 8'hD5, 0, 1'b1);

        // Read from requester 1.
        push(1, 1'b0, 3'd3, 8'h00);
        req_txn(1, 1'b0, 3'd3, 8'h00, 0, 1'b1);
        chk("read_data_held", bus.req_o_data, 8'h41);

        // Contention: both requesters, four transactions each, strict alternation.
        for (int k = 0; k < 4; k++) begin
            push(0, 1'b1, 3'(k), 8'(8'h10 + k));
            push(1, 1'b0, 3'(4 + k), 8'(8'h20 + k));
        end
        fork
            begin
                for (int k = 0; k < 4; k++) req_txn(0, 1'b1, 3'(k), 8'(8'h10 + k), 0, 1'b0);
            end
            begin
                for (int k = 0; k < 4; k++) req_txn(1, 1'b0, 3'(4 + k), 8'(8'h20 + k), 0, 1'b0);
            end
        join
        chk("contention_drained", exp_q.size(), 0);

        // Held enable: requester 0 keeps enable 10 cycles after ready while requester 1 waits.
        push(0, 1'b1, 3'd1, 8'h99);
        push(1, 1'b0, 3'd7, 8'h00);
        fork
            req_txn(0, 1'b1, 3'd1, 8'h99, 10, 1'b0);
            begin
                repeat (2) @(negedge clk);
                req_txn(1, 1'b0, 3'd7, 8'h00, 0, 1'b0);
            end
        join

        // Abandon: requester 1 drops enable and changes its fields mid-access.
        repeat (2) @(negedge clk);
        push(1, 1'b0, 3'd2, 8'h77);
        tb_wr[1] = 1'b0; tb_addr[1] = 3'd2; tb_dat[1] = 8'h77; tb_en[1] = 1'b1;
        cyc = 0;
        while (bus.m_enable !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("abandon_started", bus.m_enable, 1);
        tb_en[1] = 1'b0; tb_addr[1] = 3'd6; tb_dat[1] = 8'h00;
        @(negedge clk);
        chk("abandon_addr_held", {bus.m_addr, bus.m_i_data}, {3'd2, 8'h77});
        saw = 1'b0;
        cyc = 0;
        while (bus.m_enable === 1'b1 && cyc < 50) begin
            if (bus.req_ready !== 2'b00) saw = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (bus.req_ready !== 2'b00) saw = 1'b1;
        chk("abandon_completed", bus.m_enable, 0);
        chk("abandon_no_ready", saw, 0);
        chk("abandon_grant_clr", bus.grant, 0);
        chk("abandon_rdata", bus.req_o_data, 8'h22);
        @(negedge clk);
        chk("abandon_idle", {bus.grant, bus.m_enable, bus.req_ready}, 0);

        // Asynchronous reset in the middle of an access.
        push(0, 1'b1, 3'd5, 8'h3C);
        tb_wr[0] = 1'b1; tb_addr[0] = 3'd5; tb_dat[0] = 8'h3C; tb_en[0] = 1'b1;
        cyc = 0;
        while (bus.m_enable !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("arst_access_active", {bus.m_enable, bus.grant}, {1'b1, 2'b01});
        #2 rst = 1'b1;
        #1;
        chk("arst_m_enable", bus.m_enable, 0);
        chk("arst_grant", bus.grant, 0);
        chk("arst_rdata", bus.req_o_data, 0);
        tb_en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_arst_idle", {bus.grant, bus.m_enable}, 0);

        // Downstream never answers.
        mem_on = 1'b0;
        push(0, 1'b0, 3'd4, 8'h00);
        tb_wr[0] = 1'b0; tb_addr[0] = 3'd4; tb_dat[0] = 8'h00; tb_en[0] = 1'b1;
        cyc = 0;
        while (bus.m_enable !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("noack_started", bus.m_enable, 1);
`ifdef UART_ARB_TIMEOUT_EN
        cyc = 0;
        while (bus.req_ready[0] !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_cycles", cyc, TO);
        chk("timeout_rdata", bus.req_o_data, 8'hFF);
        chk("timeout_err_set", bus.timeout_err, 1);
        chk("timeout_m_enable", bus.m_enable, 0);
        @(negedge clk);
        tb_en[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("timeout_err_sticky", bus.timeout_err, 1);
        chk("timeout_idle", bus.grant, 0);
`else
        repeat (40) @(negedge clk);
        chk("noack_enable_held", bus.m_enable, 1);
        chk("noack_no_ready", bus.req_ready, 0);
        chk("noack_no_err", bus.timeout_err, 0);
        tb_en[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("noack_reset_idle", {bus.grant, bus.m_enable}, 0);
`endif
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
